grf_regfile: RTL and testbench
==============================

Name: grf_regfile

Overview:
- General-purpose register file for the single-cycle MIPS datapath.
- Sits between the instruction fetch unit and the ALU/branch-compare logic:
  - rs/rt fields of the fetched instruction address the read ports.
  - Read port 1 supplies the jump-register target address back to the fetch unit.
  - Write port is driven by the writeback mux (ALU result, memory data, or PC+4 for link).
- Registered trace outputs report each architectural write, so the bench can compare against the reference simulator's "@pc: $reg <= data" log.

Parameters:
- DATA_W, 32, register and data width.
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads return the pre-write value.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, asynchronous, active-high.
- ra1  input  5  read address 1 (rs).
- ra2  input  5  read address 2 (rt).
- rd1  output  DATA_W  read data 1 (also the jr target).
- rd2  output  DATA_W  read data 2.
- we  input  1  write enable.
- wa  input  5  write address (rd, rt, or 31 for link).
- wd  input  DATA_W  write data.
- wpc  input  32  PC of the instruction performing the write.
- trace_valid  output  1  one-cycle pulse: an architectural write committed on the previous edge.
- trace_pc  output  32  PC of the committed write.
- trace_addr  output  5  register written.
- trace_data  output  DATA_W  value written.

Behaviour:
- Storage: 32 x DATA_W array.
  - Register 0 is never written and always reads 0.
- Reset, asynchronous, takes effect immediately:
  - All 32 registers cleared to 0.
  - trace_valid=0, trace_pc=0, trace_addr=0, trace_data=0.
  - Reset wins over a write on the same edge: no write, no trace.
- Write, at posedge clk when reset=0:
  - If we=1 and wa!=0: reg[wa] <= wd.
  - If we=1 and wa==0: array unchanged, no trace pulse.
  - If we=0: array unchanged.
- Read is combinational, zero latency:
  - rdN = 0 if raN==0; otherwise reg[raN].
  - If BYPASS=1 and we=1 and wa==raN and wa!=0, then rdN = wd (same-cycle forwarding).
  - Both ports may hit the same register; both see identical data, bypassed or not.
- Trace, registered at each non-reset posedge:
  - trace_valid <= we && (wa!=0).
  - When the write is valid: trace_pc <= wpc, trace_addr <= wa, trace_data <= wd.
  - When not valid: trace_pc/addr/data hold their previous values and only trace_valid drops to 0.
- Back-to-back writes to the same register on consecutive edges:
  - Each produces its own trace pulse.
  - The final array value is the last write.
- Simulation-only display of each committed write, format "@%h: $%d <= %h", printed on the same edge as the array update.
- No X propagation: reads of never-written registers return 0 after reset.

Decomposition:
- Shared package (mips_pkg) holds:
  - REG_ZERO = 5'd0, REG_RA = 5'd31.
  - DATA_W default 32.
  - Reset PC 32'h3000, so wpc checks and the fetch unit agree.
- One sub-module is natural: grf_read_port.
  - Combinational zero-check plus bypass mux.
  - Instantiated twice.
  - Parameterised by DATA_W and BYPASS.

Test Plan:
- Write, then read:
  - Stimulus: reset, then we=1 wa=8 wd=32'h0000_1234 wpc=32'h3000 on one edge; next cycle ra1=8.
  - Required: rd1=32'h0000_1234; trace_valid=1 for exactly one cycle with trace_pc=32'h3000, trace_addr=8, trace_data=32'h0000_1234.
- $0 protection:
  - Stimulus: we=1 wa=0 wd=32'hFFFF_FFFF; then ra1=0, ra2=0.
  - Required: rd1=rd2=0; trace_valid stays 0.
- Bypass:
  - Stimulus: BYPASS=1, reg 9 = 5; same cycle we=1 wa=9 wd=7, ra1=9.
  - Required: rd1=7 before the edge.
  - With BYPASS=0 the same stimulus gives rd1=5 before the edge and 7 after.
- Link write:
  - Stimulus: we=1 wa=31 wd=32'h0000_3008 wpc=32'h3004.
  - Required: next cycle rd2 (ra2=31) = 32'h0000_3008; trace_addr=31.
- Reset mid-operation:
  - Stimulus: registers 1..31 loaded with nonzero values; assert reset asynchronously between edges while we=1.
  - Required: all reads return 0 immediately; trace_valid=0; no write occurs on the edge coinciding with reset.
- Consecutive writes:
  - Stimulus: wa=3 with wd=1, 2, 3 on three consecutive edges.
  - Required: three trace pulses with data 1, 2, 3; final rd1(ra1=3)=3.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: special register numbers, data width, reset PC.
package mips_pkg;

   localparam logic [4:0]  REG_ZERO   = 5'd0;
   localparam logic [4:0]  REG_RA     = 5'd31;
   localparam int          DATA_W_DEF = 32;
   localparam int          NUM_REGS   = 32;
   localparam int          NUM_RPORTS = 2;
   localparam logic [31:0] RESET_PC   = 32'h0000_3000;

endpackage

// File: rtl/grf_read_port.sv
// One combinational register-file read port: $0 forced to zero, optional
// same-cycle forwarding of the in-flight write.
module grf_read_port
   import mips_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int BYPASS = 1
) (
   input  logic [4:0]                        ra,
   input  logic [NUM_REGS-1:0][DATA_W-1:0]   regs,
   input  logic                              we,
   input  logic [4:0]                        wa,
   input  logic [DATA_W-1:0]                 wd,
   output logic [DATA_W-1:0]                 rd
);

   // Zero-check first, then let a matching write override the stored word.
   always_comb begin
      rd = '0;
      if (ra != REG_ZERO) begin
         rd = regs[ra];
         if ((BYPASS != 0) && we && (wa == ra))
            rd = wd;
      end
   end

endmodule

// File: rtl/grf_regfile.sv
// 32 x DATA_W general-purpose register file, two combinational read ports,
// one write port and a registered write-trace for the reference log compare.
module grf_regfile
   import mips_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int BYPASS = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [4:0]        ra1,
   input  logic [4:0]        ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   input  logic              we,
   input  logic [4:0]        wa,
   input  logic [DATA_W-1:0] wd,
   input  logic [31:0]       wpc,
   output logic              trace_valid,
   output logic [31:0]       trace_pc,
   output logic [4:0]        trace_addr,
   output logic [DATA_W-1:0] trace_data
);

   logic [NUM_REGS-1:0][DATA_W-1:0]   regs;
   logic [NUM_RPORTS-1:0][4:0]        ra_v;
   logic [NUM_RPORTS-1:0][DATA_W-1:0] rd_v;
   logic                              wr_ok;

   // A write to $0 is architecturally a no-op, including for the trace.
   assign wr_ok = we && (wa != REG_ZERO);

   // Storage: async clear, then commit the write; entry 0 is never loaded.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         regs <= '0;
      else if (wr_ok)
         regs[wa] <= wd;
   end

   // Trace: valid pulses per committed write, payload holds between writes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         trace_valid <= 1'b0;
         trace_pc    <= '0;
         trace_addr  <= '0;
         trace_data  <= '0;
      end else begin
         trace_valid <= wr_ok;
         if (wr_ok) begin
            trace_pc   <= wpc;
            trace_addr <= wa;
            trace_data <= wd;
         end
      end
   end

   assign ra_v = {ra2, ra1};

   for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rport
      grf_read_port #(
         .DATA_W (DATA_W),
         .BYPASS (BYPASS)
      ) u_rport (
         .ra   (ra_v[p]),
         .regs (regs),
         .we   (we),
         .wa   (wa),
         .wd   (wd),
         .rd   (rd_v[p])
      );
   end

   assign rd1 = rd_v[0];
   assign rd2 = rd_v[1];

endmodule

// File: tb/tb_grf_regfile.sv
// Bench for grf_regfile: a bypassing and a non-bypassing instance share the
// same stimulus; a register-array model is checked every cycle, plus directed
// literal checks from the test plan.
module tb_grf_regfile;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  ra1, ra2, wa;
   logic        we;
   logic [31:0] wd, wpc;

   logic [31:0] rd1_b, rd2_b, tpc_b, tdata_b;
   logic [4:0]  taddr_b;
   logic        tv_b;
   logic [31:0] rd1_n, rd2_n, tpc_n, tdata_n;
   logic [4:0]  taddr_n;
   logic        tv_n;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   grf_regfile #(.DATA_W(32), .BYPASS(1)) dut (
      .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
      .we(we), .wa(wa), .wd(wd), .wpc(wpc),
      .trace_valid(tv_b), .trace_pc(tpc_b), .trace_addr(taddr_b), .trace_data(tdata_b));

   grf_regfile #(.DATA_W(32), .BYPASS(0)) dut_nb (
      .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
      .we(we), .wa(wa), .wd(wd), .wpc(wpc),
      .trace_valid(tv_n), .trace_pc(tpc_n), .trace_addr(taddr_n), .trace_data(tdata_n));

   // ---------------- reference model ----------------
   logic [31:0] m_reg [32];
   logic        m_tv;
   logic [31:0] m_tpc, m_tdata;
   logic [4:0]  m_taddr;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) m_reg[i] <= 32'd0;
         m_tv <= 1'b0; m_tpc <= 32'd0; m_taddr <= 5'd0; m_tdata <= 32'd0;
      end else begin
         m_tv <= we && (wa != 5'd0);
         if (we && wa != 5'd0) begin
            m_reg[wa] <= wd;
            m_tpc <= wpc; m_taddr <= wa; m_tdata <= wd;
            $display("@%h: $%d <= %h", wpc, wa, wd);
         end
      end
   end

   function automatic logic [31:0] m_read(input logic [4:0] a, input bit byp);
      if (a == 5'd0) return 32'd0;
      if (byp && we && wa == a) return wd;
      return m_reg[a];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Per-cycle compare of both instances against the model.
   bit run_cmp = 1'b0;
   always @(negedge clk) begin
      if (run_cmp) begin
         chk("cmp rd1 byp",   rd1_b, m_read(ra1, 1'b1));
         chk("cmp rd2 byp",   rd2_b, m_read(ra2, 1'b1));
         chk("cmp rd1 nobyp", rd1_n, m_read(ra1, 1'b0));
         chk("cmp rd2 nobyp", rd2_n, m_read(ra2, 1'b0));
         chk("cmp tvalid",    {31'd0, tv_b},    {31'd0, m_tv});
         chk("cmp tpc",       tpc_b,            m_tpc);
         chk("cmp taddr",     {27'd0, taddr_b}, {27'd0, m_taddr});
         chk("cmp tdata",     tdata_b,          m_tdata);
         chk("cmp tvalid nb", {31'd0, tv_n},    {31'd0, m_tv});
         chk("cmp tdata nb",  tdata_n,          m_tdata);
      end
   end

   // Advance to just after the next rising edge, then drive.
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic drv(input logic w, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
      we = w; wa = a; wd = d; wpc = pc;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      reset = 1'b1; we = 1'b0; wa = 5'd0; wd = 32'd0; wpc = RESET_PC;
      ra1 = 5'd8; ra2 = 5'd31;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset rd1",    rd1_b, 32'd0);
      chk("reset tvalid", {31'd0, tv_b}, 32'd0);
      chk("reset tpc",    tpc_b, 32'd0);
      step();
      reset = 1'b0;
      run_cmp = 1'b1;

      // Write then read
      drv(1'b1, 5'd8, 32'h0000_1234, 32'h0000_3000);
      @(negedge clk);
      chk("wr8 bypass same cycle", rd1_b, 32'h0000_1234);
      chk("wr8 nobyp same cycle",  rd1_n, 32'd0);
      step(); drv(1'b0, 5'd0, 32'd0, 32'd0);
      @(negedge clk);
      chk("wr8 read",   rd1_b, 32'h0000_1234);
      chk("wr8 read nb", rd1_n, 32'h0000_1234);
      chk("wr8 tvalid", {31'd0, tv_b}, 32'd1);
      chk("wr8 tpc",    tpc_b, 32'h0000_3000);
      chk("wr8 taddr",  {27'd0, taddr_b}, 32'd8);
      chk("wr8 tdata",  tdata_b, 32'h0000_1234);
      step();
      @(negedge clk);
      chk("wr8 tvalid drops", {31'd0, tv_b}, 32'd0);
      chk("wr8 tdata holds",  tdata_b, 32'h0000_1234);

      // $0 protection
      ra1 = 5'd0; ra2 = 5'd0;
      drv(1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0000_3008);
      @(negedge clk);
      chk("r0 rd1 byp", rd1_b, 32'd0);
      chk("r0 rd2 byp", rd2_b, 32'd0);
      step(); drv(1'b0, 5'd0, 32'd0, 32'd0);
      @(negedge clk);
      chk("r0 rd1 after", rd1_b, 32'd0);
      chk("r0 rd2 after", rd2_n, 32'd0);
      chk("r0 no trace",  {31'd0, tv_b}, 32'd0);

      // Bypass vs no-bypass
      ra1 = 5'd9; ra2 = 5'd9;
      drv(1'b1, 5'd9, 32'd5, 32'h0000_300C);
      step(); drv(1'b1, 5'd9, 32'd7, 32'h0000_3010);
      @(negedge clk);
      chk("byp rd1",      rd1_b, 32'd7);
      chk("byp rd2",      rd2_b, 32'd7);
      chk("nobyp rd1 pre", rd1_n, 32'd5);
      step(); drv(1'b0, 5'd0, 32'd0, 32'd0);
      @(negedge clk);
      chk("nobyp rd1 post", rd1_n, 32'd7);

      // Link write
      drv(1'b1, REG_RA, 32'h0000_3008, 32'h0000_3004);
      step(); drv(1'b0, 5'd0, 32'd0, 32'd0);
      ra2 = 5'd31;
      @(negedge clk);
      chk("link rd2",   rd2_b, 32'h0000_3008);
      chk("link taddr", {27'd0, taddr_b}, 32'd31);
      chk("link tpc",   tpc_b, 32'h0000_3004);

      // Consecutive writes to $3
      ra1 = 5'd3;
      for (int k = 1; k <= 3; k++) begin
         if (k > 1) step();
         drv(1'b1, 5'd3, k, 32'h0000_3010 + 4 * k);
         if (k > 1) begin
            @(negedge clk);
            chk("seq tvalid", {31'd0, tv_b}, 32'd1);
            chk("seq tdata",  tdata_b, k - 1);
         end
      end
      step(); drv(1'b0, 5'd0, 32'd0, 32'd0);
      @(negedge clk);
      chk("seq last tvalid", {31'd0, tv_b}, 32'd1);
      chk("seq last tdata",  tdata_b, 32'd3);
      chk("seq rd1",         rd1_b, 32'd3);

      // Fill 1..31, then async reset between edges while a write is pending
      for (int i = 1; i < 32; i++) begin
         step(); drv(1'b1, 5'(i), 32'h1111_0000 + i, 32'h0000_3100 + 4 * i);
      end
      step(); drv(1'b1, 5'd5, 32'hDEAD_BEEF, 32'h0000_3200);
      ra1 = 5'd7; ra2 = 5'd31;
      @(negedge clk);
      chk("fill r7",  rd1_b, 32'h1111_0007);
      chk("fill r31", rd2_n, 32'h1111_001F);
      #2 reset = 1'b1;
      #1;
      chk("async rst rd1",    rd1_b, 32'd0);
      chk("async rst rd2",    rd2_n, 32'd0);
      chk("async rst tvalid", {31'd0, tv_b}, 32'd0);
      step();
      @(negedge clk);
      chk("rst edge tvalid", {31'd0, tv_b}, 32'd0);
      reset = 1'b0;
      drv(1'b0, 5'd0, 32'd0, 32'd0);
      ra1 = 5'd5;
      #1;
      chk("rst edge no write", rd1_b, 32'd0);
      step();
      @(negedge clk);
      chk("post rst r5", rd1_n, 32'd0);
      run_cmp = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
